double_buffer_filler: RTL and testbench

- Write-side feeder directly upstream of the double buffer.
- Accepts a narrow valid/ready input stream and packs it into DATA_WIDTH words. Drives wen/wadr/wdata into the write bank.
- Once a bank is complete and the reader has released its bank, issues a one-cycle switch_banks pulse and reports how many words the new read bank holds.

---
 rtl/double_buffer_filler.sv | 133 +++++++++++++
 tb/tb_double_buffer_filler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/double_buffer_filler.sv
// double_buffer_filler: packs a narrow valid/ready beat stream into bank words
// and hands each finished bank to the reader with a one-cycle switch_banks pulse.
module double_buffer_filler #(
   parameter int DATA_WIDTH      = 64,
   parameter int IN_WIDTH        = 16,
   parameter int BANK_ADDR_WIDTH = 7,
   parameter int BANK_DEPTH      = 128
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [BANK_ADDR_WIDTH:0]   cfg_words,
   input  logic [IN_WIDTH-1:0]        din,
   input  logic                       din_valid,
   input  logic                       din_last,
   output logic                       din_rdy,
   input  logic                       reader_done,
   output logic                       wen,
   output logic [BANK_ADDR_WIDTH-1:0] wadr,
   output logic [DATA_WIDTH-1:0]      wdata,
   output logic                       switch_banks,
   output logic [BANK_ADDR_WIDTH:0]   bank_words
);
   localparam int LANES = DATA_WIDTH / IN_WIDTH;
   localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
   localparam logic [LW-1:0] LANE_ONE = LW'(1);
   localparam logic [BANK_ADDR_WIDTH:0] DEPTH_W = (BANK_ADDR_WIDTH + 1)'(BANK_DEPTH);
   localparam logic [BANK_ADDR_WIDTH:0] CNT_ONE = (BANK_ADDR_WIDTH + 1)'(1);

   typedef enum logic [1:0] {FILL, WAIT, SWITCH} state_t;

   state_t                          state_q, state_d;
   logic                            din_rdy_q, din_rdy_d;
   logic                            wen_q, wen_d;
   logic [BANK_ADDR_WIDTH-1:0]      wadr_q, wadr_d;
   logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
   logic                            switch_banks_q, switch_banks_d;
   logic [BANK_ADDR_WIDTH:0]        bank_words_q, bank_words_d;
   logic [BANK_ADDR_WIDTH:0]        cfg_q, cfg_d;
   logic [BANK_ADDR_WIDTH:0]        wcnt_q, wcnt_d;
   logic [LW-1:0]                   lane_q, lane_d;
   logic [LANES-1:0][IN_WIDTH-1:0]  pack_q, pack_d;
   logic [LANES-1:0][IN_WIDTH-1:0]  word;
   logic [BANK_ADDR_WIDTH:0]        cfg_eff;
   logic                            accept, close;

   assign din_rdy      = din_rdy_q;
   assign wen          = wen_q;
   assign wadr         = wadr_q;
   assign wdata        = wdata_q;
   assign switch_banks = switch_banks_q;
   assign bank_words   = bank_words_q;

   assign cfg_eff = (cfg_words == '0 || cfg_words > DEPTH_W) ? DEPTH_W : cfg_words;
   assign accept  = din_valid & din_rdy_q;
   assign close   = accept & (din_last | lane_q == LAST_LANE);

   always_comb begin
      word = pack_q;
      word[lane_q] = din;
      state_d = state_q;
      din_rdy_d = din_rdy_q;
      wen_d = 1'b0;
      wadr_d = wadr_q;
      wdata_d = wdata_q;
      switch_banks_d = 1'b0;
      bank_words_d = bank_words_q;
      cfg_d = cfg_q;
      wcnt_d = wcnt_q;
      lane_d = lane_q;
      pack_d = pack_q;
      // FILL with din_rdy low only happens on the first cycle out of reset
      if (state_q == FILL && !din_rdy_q) begin
         cfg_d = cfg_eff;
         din_rdy_d = 1'b1;
      end
      if (accept) begin
         lane_d = close ? '0 : lane_q + LANE_ONE;
         pack_d = close ? '0 : word;
      end
      if (close) begin
         wen_d = 1'b1;
         wadr_d = wcnt_q[BANK_ADDR_WIDTH-1:0];
         wdata_d = word;
         wcnt_d = wcnt_q + CNT_ONE;
         if (din_last || wcnt_q == cfg_q - CNT_ONE) begin
            state_d = WAIT;
            din_rdy_d = 1'b0;
         end
      end
      if (state_q == WAIT && reader_done) begin
         state_d = SWITCH;
         switch_banks_d = 1'b1;
         bank_words_d = wcnt_q;
      end
      if (state_q == SWITCH) begin
         state_d = FILL;
         din_rdy_d = 1'b1;
         cfg_d = cfg_eff;
         wcnt_d = '0;
         lane_d = '0;
         pack_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         din_rdy_q <= 1'b0;
         wen_q <= 1'b0;
         wadr_q <= '0;
         wdata_q <= '0;
         switch_banks_q <= 1'b0;
         bank_words_q <= '0;
         cfg_q <= '0;
         wcnt_q <= '0;
         lane_q <= '0;
         pack_q <= '0;
      end else begin
         state_q <= state_d;
         din_rdy_q <= din_rdy_d;
         wen_q <= wen_d;
         wadr_q <= wadr_d;
         wdata_q <= wdata_d;
         switch_banks_q <= switch_banks_d;
         bank_words_q <= bank_words_d;
         cfg_q <= cfg_d;
         wcnt_q <= wcnt_d;
         lane_q <= lane_d;
         pack_q <= pack_d;
      end
   end
endmodule

// File: tb/tb_double_buffer_filler.sv
// tb_double_buffer_filler: directed timing steps followed by random banks
// checked against a queue-based packing model.
module tb_double_buffer_filler;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  cfg_words = 8'd3;
   logic [15:0] din = '0;
   logic        din_valid = 1'b0;
   logic        din_last = 1'b0;
   logic        din_rdy;
   logic        reader_done = 1'b1;
   logic        wen;
   logic [6:0]  wadr;
   logic [63:0] wdata;
   logic        switch_banks;
   logic [7:0]  bank_words;

   double_buffer_filler dut (
      .clk(clk), .rst_n(rst_n), .cfg_words(cfg_words), .din(din),
      .din_valid(din_valid), .din_last(din_last), .din_rdy(din_rdy),
      .reader_done(reader_done), .wen(wen), .wadr(wadr), .wdata(wdata),
      .switch_banks(switch_banks), .bank_words(bank_words)
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] d; logic l; } beat_t;

   int passed = 0;
   int total = 0;
   logic overlap = 1'b0;
   logic [6:0]  got_a[$];
   logic [63:0] got_d[$];
   logic [7:0]  got_s[$];
   beat_t       beats[$];
   logic [6:0]  exp_a[$];
   logic [63:0] exp_d[$];
   logic [7:0]  exp_s[$];
   int cfgs[6] = '{1, 5, 0, 2, 200, 3};
   int last_en[6] = '{0, 1, 0, 1, 0, 0};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (wen) begin
         got_a.push_back(wadr);
         got_d.push_back(wdata);
      end
      if (switch_banks) got_s.push_back(bank_words);
      if (wen && switch_banks) overlap = 1'b1;
   endtask

   task automatic beat(input logic [15:0] d, input logic l);
      din = d;
      din_last = l;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      din_last = 1'b0;
   endtask

   initial begin
      int idx, nsw, cyc, n;
      logic bad;
      // reset held across edges
      repeat (3) tick();
      chk("rst_wen", wen, 0);
      chk("rst_wadr", wadr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_switch", switch_banks, 0);
      chk("rst_bank_words", bank_words, 0);
      chk("rst_rdy", din_rdy, 0);
      rst_n = 1'b1;
      tick();
      chk("rel_rdy", din_rdy, 1);
      chk("rel_wen", wen, 0);
      chk("rel_switch", switch_banks, 0);
      // packing and full bank of 3 words
      beat(16'h1111, 0); beat(16'h2222, 0); beat(16'h3333, 0);
      chk("pack_no_early_wen", wen, 0);
      beat(16'h4444, 0);
      chk("pack_wen", wen, 1);
      chk("pack_wadr", wadr, 0);
      chk("pack_wdata", wdata, 64'h4444_3333_2222_1111);
      for (int i = 0; i < 8; i++) beat(16'(i + 5), 0);
      chk("full_last_wen", wen, 1);
      chk("full_last_wadr", wadr, 2);
      chk("full_rdy_low", din_rdy, 0);
      chk("full_no_switch_yet", switch_banks, 0);
      tick();
      chk("full_switch", switch_banks, 1);
      chk("full_bank_words", bank_words, 3);
      chk("full_switch_no_wen", wen, 0);
      tick();
      chk("full_switch_end", switch_banks, 0);
      chk("full_rdy_back", din_rdy, 1);
      // backpressure from the reader
      reader_done = 1'b0;
      for (int i = 0; i < 4; i++) beat(16'(i + 32'h100), 0);
      chk("bp_first_wadr", wadr, 0);
      chk("bp_first_wen", wen, 1);
      for (int i = 0; i < 8; i++) beat(16'(i + 32'h200), 0);
      chk("bp_last_wadr", wadr, 2);
      bad = 1'b0;
      repeat (50) begin
         tick();
         if (din_rdy || switch_banks) bad = 1'b1;
      end
      chk("bp_hold", bad, 0);
      reader_done = 1'b1;
      tick();
      chk("bp_switch", switch_banks, 1);
      chk("bp_bank_words", bank_words, 3);
      tick();
      chk("bp_rdy_back", din_rdy, 1);
      // early last
      for (int i = 1; i <= 4; i++) beat(16'(i), 0);
      chk("early_w0_adr", wadr, 0);
      chk("early_w0_data", wdata, 64'h0004_0003_0002_0001);
      beat(16'h0005, 0);
      chk("early_mid_wen", wen, 0);
      beat(16'h0006, 1);
      chk("early_w1_wen", wen, 1);
      chk("early_w1_adr", wadr, 1);
      chk("early_w1_data", wdata, 64'h0000_0000_0006_0005);
      chk("early_rdy_low", din_rdy, 0);
      tick();
      chk("early_switch", switch_banks, 1);
      chk("early_bank_words", bank_words, 2);
      tick();
      // async reset in the middle of word 1
      for (int i = 0; i < 6; i++) beat(16'(i + 32'hA0), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rdy", din_rdy, 0);
      chk("arst_wen", wen, 0);
      chk("arst_wdata", wdata, 0);
      #3 rst_n = 1'b1;
      tick();
      chk("arst_rel_rdy", din_rdy, 1);
      chk("arst_rel_wen", wen, 0);
      beat(16'hC001, 0); beat(16'hC002, 0); beat(16'hC003, 0); beat(16'hC004, 1);
      chk("arst_wadr", wadr, 0);
      chk("arst_wdata_new", wdata, 64'hC004_C003_C002_C001);
      tick();
      chk("arst_bank_words", bank_words, 1);
      cfg_words = 8'(cfgs[0]);
      // random banks against the packing model
      got_a.delete(); got_d.delete(); got_s.delete();
      for (int b = 0; b < 6; b++) begin
         int eff, words, lane;
         logic [63:0] acc;
         logic done;
         eff = (cfgs[b] == 0 || cfgs[b] > 128) ? 128 : cfgs[b];
         words = 0; lane = 0; acc = '0; done = 1'b0;
         while (!done) begin
            beat_t bt;
            bt.d = 16'($urandom);
            bt.l = last_en[b] != 0 && $urandom_range(0, 7) == 0;
            beats.push_back(bt);
            acc |= 64'(bt.d) << (16 * lane);
            lane++;
            if (lane == 4 || bt.l) begin
               exp_a.push_back(7'(words));
               exp_d.push_back(acc);
               words++; acc = '0; lane = 0;
               if (words == eff || bt.l) begin
                  exp_s.push_back(8'(words));
                  done = 1'b1;
               end
            end
         end
      end
      idx = 0; nsw = 0; cyc = 0; n = beats.size();
      while (idx < n && cyc < 20000) begin
         logic acc_now;
         din = beats[idx].d;
         din_last = beats[idx].l;
         din_valid = $urandom_range(0, 3) != 0;
         reader_done = $urandom_range(0, 9) < 7;
         acc_now = din_valid && din_rdy;
         tick();
         cyc++;
         if (acc_now) idx++;
         if (switch_banks) begin
            nsw++;
            if (nsw < 6) cfg_words = 8'(cfgs[nsw]);
         end
      end
      din_valid = 1'b0;
      din_last = 1'b0;
      reader_done = 1'b1;
      chk("rand_all_beats_taken", idx, n);
      cyc = 0;
      while (got_s.size() < exp_s.size() && cyc < 200) begin
         tick();
         cyc++;
      end
      chk("rand_write_count", got_a.size(), exp_a.size());
      chk("rand_switch_count", got_s.size(), exp_s.size());
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         chk($sformatf("rand_wadr[%0d]", i), got_a[i], exp_a[i]);
         chk($sformatf("rand_wdata[%0d]", i), got_d[i], exp_d[i]);
      end
      for (int i = 0; i < exp_s.size() && i < got_s.size(); i++)
         chk($sformatf("rand_bank_words[%0d]", i), got_s[i], exp_s[i]);
      chk("no_wen_with_switch", overlap, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
